// File: rtl/rc4_keystream_core.sv
// rtl/rc4_keystream_core.sv - RC4 key scheduling and keystream generation core
module rc4_keystream_core #(
    parameter int NUMS_OF_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [31:0]                key,
    input  logic [7:0]                 key_length,
    output logic [NUMS_OF_BYTES*8-1:0] k_addr,
    output logic [NUMS_OF_BYTES*8-1:0] ckey,
    output logic                       done
);

    localparam int        W      = NUMS_OF_BYTES * 8;
    localparam logic [4:0] LAST_B = 5'(NUMS_OF_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // S-box: plain register array, read combinationally so a full
    // KSA or PRGA iteration (read, sum, swap) retires every cycle.
    logic [7:0] r_sbox [256];

    logic [7:0]   r_i;
    logic [7:0]   r_j;
    logic [1:0]   r_kidx;
    logic [2:0]   r_klen;
    logic [31:0]  r_key;
    logic [4:0]   r_b;
    logic [W-1:0] r_ckey;
    logic [W-1:0] r_kaddr;

    logic [2:0] w_klen_eff;
    logic [7:0] w_kbyte;
    logic [1:0] w_kidx_next;

    logic [7:0] w_ksa_si;
    logic [7:0] w_ksa_j;
    logic [7:0] w_ksa_sj;

    logic [7:0] w_pi;
    logic [7:0] w_psi;
    logic [7:0] w_pj;
    logic [7:0] w_psj;
    logic [7:0] w_t;
    logic [7:0] w_st;
    logic [7:0] w_byte;

    // Effective key length: 1..4 used as given, anything else means 4.
    always_comb begin
        w_klen_eff = 3'd4;
        if (key_length >= 8'd1 && key_length <= 8'd4) begin
            w_klen_eff = key_length[2:0];
        end
    end

    // Key byte for the current KSA step and the wrapping key-index counter.
    always_comb begin
        w_kbyte = r_key[7:0];
        case (r_kidx)
            2'd0:    w_kbyte = r_key[7:0];
            2'd1:    w_kbyte = r_key[15:8];
            2'd2:    w_kbyte = r_key[23:16];
            default: w_kbyte = r_key[31:24];
        endcase
        w_kidx_next = r_kidx + 2'd1;
        if ({1'b0, r_kidx} == (r_klen - 3'd1)) begin
            w_kidx_next = 2'd0;
        end
    end

    // KSA step: j' = j + S[i] + K, then S[i] and S[j'] trade places.
    always_comb begin
        w_ksa_si = r_sbox[r_i];
        w_ksa_j  = r_j + w_ksa_si + w_kbyte;
        w_ksa_sj = r_sbox[w_ksa_j];
    end

    // PRGA step: the output byte is read from the post-swap S-box, so the
    // two swapped slots are forwarded instead of read from the array.
    always_comb begin
        w_pi   = r_i + 8'd1;
        w_psi  = r_sbox[w_pi];
        w_pj   = r_j + w_psi;
        w_psj  = r_sbox[w_pj];
        w_t    = w_psi + w_psj;
        w_st   = r_sbox[w_t];
        w_byte = w_st;
        if (w_t == w_pi) begin
            w_byte = w_psj;
        end else if (w_t == w_pj) begin
            w_byte = w_psi;
        end
    end

    // Next-state logic; a held start in DONE waits for a low phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_INIT;
            ST_INIT: w_next = ST_KSA;
            ST_KSA:  if (r_i == 8'hFF) w_next = ST_PRGA;
            ST_PRGA: if (r_b == LAST_B) w_next = ST_DONE;
            ST_DONE: if (!start) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // S-box updates: identity fill, KSA swap, PRGA swap. Contents are not reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            for (int x = 0; x < 256; x++) begin
                r_sbox[x] <= 8'(x);
            end
        end else if (r_state == ST_KSA) begin
            r_sbox[r_i]     <= w_ksa_sj;
            r_sbox[w_ksa_j] <= w_ksa_si;
        end else if (r_state == ST_PRGA) begin
            r_sbox[w_pi] <= w_psj;
            r_sbox[w_pj] <= w_psi;
        end
    end

    // Indices, latched key and packed results.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= 2'd0;
            r_klen  <= 3'd4;
            r_key   <= 32'd0;
            r_b     <= 5'd0;
            r_ckey  <= '0;
            r_kaddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key  <= key;
                        r_klen <= w_klen_eff;
                    end
                end
                ST_INIT: begin
                    r_i     <= 8'd0;
                    r_j     <= 8'd0;
                    r_kidx  <= 2'd0;
                    r_b     <= 5'd0;
                    r_ckey  <= '0;
                    r_kaddr <= '0;
                end
                ST_KSA: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= w_kidx_next;
                    if (r_i == 8'hFF) begin
                        r_j <= 8'd0;
                        r_b <= 5'd0;
                    end else begin
                        r_j <= w_ksa_j;
                    end
                end
                ST_PRGA: begin
                    r_i <= w_pi;
                    r_j <= w_pj;
                    r_b <= r_b + 5'd1;
                    for (int b = 0; b < NUMS_OF_BYTES; b++) begin
                        if (r_b == 5'(b)) begin
                            r_ckey[b*8 +: 8]  <= w_byte;
                            r_kaddr[b*8 +: 8] <= w_t;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ckey   = r_ckey;
    assign k_addr = r_kaddr;
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_rc4_keystream_core.sv
// tb/tb_rc4_keystream_core.sv - directed bench for rc4_keystream_core
module tb_rc4_keystream_core;

    logic        clk;
    logic        rst_n;
    logic        start4;
    logic        start8;
    logic [31:0] key;
    logic [7:0]  key_length;
    logic [31:0] k_addr4;
    logic [31:0] ckey4;
    logic        done4;
    logic [63:0] k_addr8;
    logic [63:0] ckey8;
    logic        done8;

    int checks;
    int errors;

    rc4_keystream_core #(.NUMS_OF_BYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .key(key), .key_length(key_length),
        .k_addr(k_addr4), .ckey(ckey4), .done(done4)
    );

    rc4_keystream_core #(.NUMS_OF_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .key(key), .key_length(key_length),
        .k_addr(k_addr8), .ckey(ckey8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RC4 using plain modulo arithmetic.
    task automatic rc4_model(input logic [31:0] k, input int len, input int n,
                             output logic [127:0] ks, output logic [127:0] ta);
        int s [256];
        int i;
        int j;
        int t;
        int tmp;
        int l;
        l = (len < 1 || len > 4) ? 4 : len;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'((k >> (8 * (x % l))) & 32'hFF)) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        i = 0; j = 0; ks = '0; ta = '0;
        for (int b = 0; b < n; b++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            t = (s[i] + s[j]) % 256;
            ks[b*8 +: 8] = 8'(s[t]);
            ta[b*8 +: 8] = 8'(t);
        end
    endtask

    // Counts posedges until done4 is seen (bounded).
    task automatic wait_done4(output int cycles);
        cycles = 0;
        while (done4 !== 1'b1 && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic go_idle4;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (done4 !== 1'b0 || ckey4 !== 32'd0 || k_addr4 !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: done=%b ckey=%h k_addr=%h required 0/0/0", done4, ckey4, k_addr4);
        end
        checks++;
        if (done8 !== 1'b0 || ckey8 !== 64'd0 || k_addr8 !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs8: done=%b ckey=%h k_addr=%h required 0/0/0", done8, ckey8, k_addr8);
        end
        begin
            int seen;
            seen = 0;
            repeat (300) begin
                @(posedge clk); #1;
                if (done4 !== 1'b0 || ckey4 !== 32'd0) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL idle_stays: %0d cycles left IDLE, required 0", seen);
            end
        end
    endtask

    task automatic test_key;
        logic [127:0] ks;
        logic [127:0] ta;
        int cyc;
        rc4_model(32'h0079654B, 3, 4, ks, ta);
        @(negedge clk);
        key = 32'h0079654B; key_length = 8'd3; start4 = 1'b1;
        wait_done4(cyc);
        checks++;
        if (cyc != 262) begin
            errors++;
            $display("FAIL key_latency: done after %0d edges, required 262", cyc);
        end
        checks++;
        if (ckey4 !== 32'h81779FEB) begin
            errors++;
            $display("FAIL key_ckey: got %h required 81779feb", ckey4);
        end
        checks++;
        if (k_addr4 !== ta[31:0]) begin
            errors++;
            $display("FAIL key_kaddr: got %h required %h", k_addr4, ta[31:0]);
        end
    endtask

    task automatic test_hold_and_rerun;
        int cyc;
        int bad;
        go_idle4();
        key = 32'h696B6957; key_length = 8'd4; start4 = 1'b1;
        wait_done4(cyc);
        checks++;
        if (cyc != 262 || ckey4 !== 32'h6DDB4460) begin
            errors++;
            $display("FAIL wiki_ckey: got %h after %0d edges required 6ddb4460 after 262", ckey4, cyc);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done4 !== 1'b1 || ckey4 !== 32'h6DDB4460) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_no_retrigger: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0) begin
            errors++;
            $display("FAIL done_fall: done=%b required 0", done4);
        end
        @(negedge clk);
        start4 = 1'b1;
        wait_done4(cyc);
        checks++;
        if (cyc != 262 || ckey4 !== 32'h6DDB4460) begin
            errors++;
            $display("FAIL wiki_rerun: got %h after %0d edges required 6ddb4460 after 262", ckey4, cyc);
        end
    endtask

    task automatic test_key_length;
        logic [127:0] ks;
        logic [127:0] ta;
        logic [7:0]   lens [3];
        int cyc;
        rc4_model(32'h40302010, 4, 4, ks, ta);
        lens[0] = 8'd4; lens[1] = 8'd0; lens[2] = 8'd8;
        for (int n = 0; n < 3; n++) begin
            go_idle4();
            key = 32'h40302010; key_length = lens[n]; start4 = 1'b1;
            cyc = 0;
            while (done4 !== 1'b1 && cyc < 400) begin
                @(posedge clk); #1;
                cyc++;
                if (n == 2 && cyc == 50) begin
                    key = 32'hDEADBEEF;
                    key_length = 8'd1;
                end
            end
            checks++;
            if (cyc != 262 || ckey4 !== ks[31:0] || k_addr4 !== ta[31:0]) begin
                errors++;
                $display("FAIL key_length_%0d: ckey=%h k_addr=%h edges=%0d required %h %h 262",
                         lens[n], ckey4, k_addr4, cyc, ks[31:0], ta[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int bad;
        go_idle4();
        key = 32'h0079654B; key_length = 8'd3; start4 = 1'b1;
        cyc = 0;
        while (cyc < 101) begin
            @(posedge clk); #1;
            cyc++;
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (done4 !== 1'b0 || ckey4 !== 32'd0 || k_addr4 !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: done=%b ckey=%h k_addr=%h required 0/0/0", done4, ckey4, k_addr4);
        end
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bad = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done4 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_abort: done seen %0d cycles, required 0", bad);
        end
        @(negedge clk);
        start4 = 1'b1;
        wait_done4(cyc);
        checks++;
        if (cyc != 262 || ckey4 !== 32'h81779FEB) begin
            errors++;
            $display("FAIL restart_key: got %h after %0d edges required 81779feb after 262", ckey4, cyc);
        end
    endtask

    task automatic test_n8;
        logic [127:0] ks;
        logic [127:0] ta;
        int cyc;
        rc4_model(32'h0079654B, 3, 8, ks, ta);
        go_idle4();
        key = 32'h0079654B; key_length = 8'd3; start8 = 1'b1;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 266) begin
            errors++;
            $display("FAIL n8_latency: done after %0d edges, required 266", cyc);
        end
        checks++;
        if (ckey8 !== 64'h72CA34B781779FEB) begin
            errors++;
            $display("FAIL n8_ckey: got %h required 72ca34b781779feb", ckey8);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (k_addr8[b*8 +: 8] !== ta[b*8 +: 8]) begin
                errors++;
                $display("FAIL n8_kaddr_%0d: got %h required %h", b, k_addr8[b*8 +: 8], ta[b*8 +: 8]);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b1;
        start4     = 1'b0;
        start8     = 1'b0;
        key        = 32'd0;
        key_length = 8'd0;
        test_reset();
        test_key();
        test_hold_and_rerun();
        test_key_length();
        test_reset_mid();
        test_n8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_keystream_core.md
Name: rc4_keystream_core

Overview:
- Self-contained RC4 keystream generator.
- On start it latches a key of up to 4 bytes and runs the RC4 key-scheduling algorithm (KSA) over an internal 256x8 S-box.
- It then produces NUMS_OF_BYTES keystream bytes (PRGA), presents them packed on ckey and raises done.
- It sits in front of stream-cipher XOR logic; test benches dump ckey bytes on the rising edge of done.

Parameters:
- NUMS_OF_BYTES, default 4: number of keystream bytes produced per run (1..16). Sets the widths of ckey and k_addr.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted when 1). Port name is kept per codebase.
- start  input  1  level request to begin a run; sampled in IDLE.
- key  input  32  key bytes; byte n = key[8n+7:8n], so byte 0 is in the LSBs.
- key_length  input  8  key length in bytes.
- k_addr  output  NUMS_OF_BYTES*8  per output byte b, the S-box index t used to fetch keystream byte b, at [8b+7:8b].
- ckey  output  NUMS_OF_BYTES*8  keystream; byte b (b=0 is the first generated byte) at [8b+7:8b].
- done  output  1  high while results are valid.

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE; i=j=0; key-index counter=0.
  - ckey=0, k_addr=0, done=0.
  - S-box contents are don't-care.
  - Reset mid-run aborts immediately. The next run starts from IDLE.
- S-box: 256x8 register array with combinational read, so each iteration completes in one cycle.
- Key handling:
  - key and key_length are latched on the edge that leaves IDLE. Later changes to the inputs have no effect on the run.
  - Effective length L = key_length when it is 1..4; when it is 0 or greater than 4, L=4.
  - Key byte for KSA step i is K[i mod L]. This is generated by a counter that wraps from L-1 to 0; no divider.
- FSM:
  - IDLE: if start=1, latch key/length and go to INIT.
  - INIT, 1 cycle: S[x]=x for all x in parallel; i=0, j=0, counter=0; go to KSA.
  - KSA, 256 cycles, one per i=0..255:
    - j' = j + S[i] + K[counter], mod 256.
    - Swap S[i] and S[j']. When i==j' the entry is unchanged.
    - i increments (wraps to 0 after 255); counter advances.
    - After i=255: j=0, i=0, output index b=0; go to PRGA.
  - PRGA, NUMS_OF_BYTES cycles, one per byte b:
    - i' = i+1; j' = j + S[i'].
    - Swap S[i'] and S[j'].
    - t = S[i'] + S[j'], using post-swap values. Byte = S[t] post-swap: if t==i' use the new S[i'], if t==j' use the new S[j'].
    - Write the byte to ckey[8b+7:8b] and t to k_addr[8b+7:8b]; update i, j.
    - After the last byte go to DONE.
  - DONE: done=1; ckey and k_addr held stable. Stay until start=0, then go to IDLE with done=0.
  - A start still held high does not retrigger. A new run needs start low, then high.
- Timing: with the start-sampling edge as edge 0, INIT occupies edge 1, KSA edges 2..257, and PRGA edges 258..257+N. done rises after edge 257+N (edge 261 for N=4).
- ckey and k_addr are cleared to 0 at INIT. Bytes fill in order during PRGA.
- All arithmetic is 8-bit modulo 256.

Test Plan:
- Reset held for 2 cycles, then released with start=0 -> done=0, ckey=0, k_addr=0; state remains IDLE indefinitely.
- key=32'h0079654B ("Key"), key_length=3, N=4, start held high -> done rises after edge 261; ckey=32'h81779FEB (bytes EB 9F 77 81).
- key=32'h696B6957 ("Wiki"), key_length=4 -> ckey=32'h6DDB4460. start kept high after done -> done stays 1 and ckey is unchanged. Drop start, then re-raise it -> done falls and the identical result is produced again.
- key=32'h40302010 with key_length=0 and then with key_length=8 -> both results are identical to the key_length=4 run. Changing key during the run has no effect.
- Assert rst_n mid-KSA (edge 100) -> all outputs return to 0 immediately. A restart after release gives the correct "Key" vector.
- NUMS_OF_BYTES=8 with key "Key" -> ckey=64'h72CA34B781779FEB. For every b, k_addr byte b equals the t index consistent with a software RC4 model.
